// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter family: FSM encoding and
// the critical-word-first line address helper.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int ADDR_MAX = 64;

  // Word index inside the line advances by beat and wraps; bits above the line stay fixed.
  function automatic logic [ADDR_MAX-1:0] wrap_line_addr(
    input logic [ADDR_MAX-1:0] base,
    input logic [ADDR_MAX-1:0] beat,
    input int unsigned         line_words
  );
    logic [ADDR_MAX-1:0] mask;
    mask = ADDR_MAX'(line_words - 1) << 2;
    return ((base & ~mask) | ((base + (beat << 2)) & mask)) & ~ADDR_MAX'(3);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N, returned one-hot plus as an index.
module rr_pick #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter placing NCH cache/walker requesters onto one memory
// port, with single-word writes and critical-word-first burst line fills.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter  int NCH        = 2,
  parameter  int AW         = 32,
  parameter  int DW         = 32,
  parameter  int LINE_WORDS = 4,
  localparam int LB         = $clog2(LINE_WORDS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_access,
  input  logic [NCH-1:0]    ch_write,
  input  logic [NCH-1:0]    ch_burst,
  input  logic [NCH*AW-1:0] ch_a,
  input  logic [NCH*DW-1:0] ch_st_data,
  output logic [NCH-1:0]    ch_rvalid,
  output logic [NCH-1:0]    ch_done,
  output logic [NCH-1:0]    ch_grant,
  output logic [DW-1:0]     ch_data,
  output logic [AW-1:0]     mem_a,
  output logic [DW-1:0]     mem_st_data,
  output logic              mem_access,
  output logic              mem_write,
  input  logic [DW-1:0]     mem_data,
  input  logic              mem_ready
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  arb_state_t      state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   grant_idx;
  logic [NCH-1:0]  grant_q;
  logic [LB-1:0]   cnt;
  logic            cap_write;
  logic            cap_burst;
  logic [AW-1:0]   cap_a;
  logic [DW-1:0]   cap_d;
  logic            access_q;
  logic            write_q;

  logic [NCH-1:0]  pick;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  logic            beat;
  logic            last_beat;
  logic [PW-1:0]   next_ptr;

  rr_pick #(.N(NCH)) u_pick (
    .req       (ch_access),
    .ptr       (rr_ptr),
    .grant     (pick),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  assign beat      = (state == BUSY) && mem_ready;
  assign last_beat = cap_write || !cap_burst || (cnt == LB'(LINE_WORDS - 1));
  assign next_ptr  = (grant_idx == PW'(NCH - 1)) ? '0 : grant_idx + 1'b1;

  // Reset mid-transaction simply abandons it; the requester re-requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      grant_q   <= '0;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_burst <= 1'b0;
      cap_a     <= '0;
      cap_d     <= '0;
      access_q  <= 1'b0;
      write_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_q   <= pick;
            grant_idx <= pick_idx;
            cap_write <= ch_write[pick_idx];
            cap_burst <= ch_burst[pick_idx] & ~ch_write[pick_idx];
            cap_a     <= ch_a[int'(pick_idx)*AW +: AW];
            cap_d     <= ch_st_data[int'(pick_idx)*DW +: DW];
            cnt       <= '0;
            access_q  <= 1'b1;
            write_q   <= ch_write[pick_idx];
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (beat) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              state    <= IDLE;
              grant_q  <= '0;
              access_q <= 1'b0;
              write_q  <= 1'b0;
              rr_ptr   <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ch_grant    = grant_q;
  assign mem_access  = access_q;
  assign mem_write   = write_q;
  assign mem_st_data = cap_d;
  assign mem_a       = AW'(wrap_line_addr(ADDR_MAX'(cap_a), ADDR_MAX'(cnt), LINE_WORDS));
  assign ch_rvalid   = (beat && !cap_write) ? grant_q : '0;
  assign ch_done     = (beat && last_beat) ? grant_q : '0;
  assign ch_data     = (|ch_rvalid) ? mem_data : '0;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised successor to the single-requester memory handshake (mem_a / mem_st_data / mem_access / mem_write / mem_ready).
- Arbitrates NCH cache/TLB-walker requesters onto one external memory port using round-robin.
- Supports single-word writes and single-word or LINE_WORDS-beat critical-word-first read bursts for cache line fills.
- Sits between the I-cache, D-cache and page-table walker and the memory model clocked by memclock.

Parameters:
- NCH, 2, number of requesting channels (2..8).
- AW, 32, address width.
- DW, 32, data width.
- LINE_WORDS, 4, beats per burst read; must be a power of two, 2..16.
- LB, $clog2(LINE_WORDS), derived; not overridable.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ch_access  in  NCH  per-channel request; held high until ch_done.
- ch_write  in  NCH  1 = single-word store, 0 = read.
- ch_burst  in  NCH  read only: 1 = line fill of LINE_WORDS beats, 0 = single word.
- ch_a  in  NCH*AW  word-aligned byte address; channel i occupies bits [i*AW +: AW].
- ch_st_data  in  NCH*DW  store data, same packing as ch_a.
- ch_rvalid  out  NCH  read beat valid to the granted channel.
- ch_done  out  NCH  one-cycle pulse on the final beat of a transaction.
- ch_grant  out  NCH  one-hot; identifies the owner during BUSY.
- ch_data  out  DW  read data, shared by all channels; qualified by ch_rvalid.
- mem_a  out  AW  memory address.
- mem_st_data  out  DW  memory store data.
- mem_access  out  1  memory request.
- mem_write  out  1  memory write enable.
- mem_data  in  DW  memory read data.
- mem_ready  in  1  beat-complete strobe from memory.

Behaviour:
- States: IDLE, BUSY.
- Reset, or reset asserted mid-transaction:
  - state = IDLE, rr_ptr = 0, beat count = 0.
  - ch_grant, mem_access, mem_write = 0.
  - The in-flight transaction is dropped, no ch_done is issued, and the requester must re-request.
- IDLE:
  - If any ch_access is high, the winner is the first set bit searching upward from rr_ptr, modulo NCH.
  - On that edge: latch the winner into grant, capture its write/burst/address/data, clear cnt, go to BUSY.
  - Latency from request to mem_access is exactly 1 cycle.
- BUSY:
  - mem_access = 1; mem_write = captured write; mem_st_data = captured data.
  - mem_a = {a[AW-1:LB+2], a[LB+1:2] + cnt, 2'b00}. The word index wraps within the line (critical word first); the upper bits never change.
  - For a single-word transaction cnt stays 0.
  - Each cycle with mem_ready=1 is one beat:
    - reads: ch_rvalid[g] = 1 and ch_data = mem_data, combinational in the same cycle;
    - cnt increments on every beat.
  - Last beat (write; single read; or burst read with cnt == LINE_WORDS-1):
    - ch_done[g] = 1 in the same cycle;
    - next state IDLE; rr_ptr = g+1 mod NCH.
  - mem_ready=0 means wait. There is no timeout.
- At least one IDLE cycle separates consecutive transactions; mem_access is low in that cycle.
- ch_access changes on non-granted channels during BUSY are ignored. The granted channel deasserting early is a protocol error; the arbiter still completes.
- ch_data = 0 whenever no ch_rvalid is set.
- mem_ready outside BUSY is ignored.
- ch_burst is ignored when ch_write = 1.
- Fairness: a requesting channel waits at most NCH-1 transactions.

Decomposition:
- Shared package mem_pkg holds:
  - state encoding (IDLE/BUSY);
  - a function computing the wrapped line address.
- Sub-module rr_pick (NCH-bit request vector plus pointer, returns a one-hot winner) is combinational and reused by future bus arbiters.
- Beat counter and state machine stay in mem_port_arbiter.

Test Plan:
- Single read, default parameters: ch0 read of 0x100, mem_ready at cycle 3 with mem_data=0xDEAD_BEEF.
  - mem_access rises 1 cycle after the request.
  - ch_rvalid[0], ch_done[0] and ch_data=0xDEAD_BEEF all appear in the mem_ready cycle.
- Burst wrap: ch1 burst from 0x2008, LINE_WORDS=4, mem_ready held high.
  - mem_a sequence is 0x2008, 0x200C, 0x2000, 0x2004.
  - 4 ch_rvalid pulses; ch_done on the 4th.
- Round-robin: ch0 and ch1 request continuously.
  - Grants alternate 0, 1, 0, 1.
  - With NCH=4 and all requesting, the grant order is 0, 1, 2, 3, 0.
- Write: ch0 writes 0xCAFE to 0x40, mem_ready after 2 cycles.
  - mem_write = 1, mem_st_data = 0xCAFE, exactly one ch_done pulse.
  - No ch_rvalid; ch_burst=1 has no effect.
- Reset mid-burst: reset asserted after beat 2 of 4.
  - The next cycle has mem_access = 0 and grant = 0, with no ch_done.
  - A re-request restarts at beat 0.
- Stall: mem_ready low for 10 cycles mid-burst.
  - mem_a and the beat count hold steady; there are no spurious ch_rvalid pulses.
